// File: rtl/dht_sensor_ctrl_pkg.sv
// Shared types and helpers for the DHT11/DHT22 host controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dht_sensor_ctrl_pkg;

    localparam int FRAME_W = 40;

    typedef enum logic {
        DHT11 = 1'b0,
        DHT22 = 1'b1
    } dht_mode_e;

    // 4-bit encodings are exported on the state port for debug LEDs
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_WAIT   = 4'd2,
        ST_SYNC_L = 4'd3,
        ST_SYNC_H = 4'd4,
        ST_DATA_L = 4'd5,
        ST_DATA_H = 4'd6,
        ST_STOP   = 4'd7,
        ST_CHECK  = 4'd8,
        ST_ABORT  = 4'd9
    } dht_state_e;

    // Sensor checksum: low byte of the sum of the four payload bytes
    function automatic logic [7:0] frame_checksum(input logic [FRAME_W-1:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s;
    endfunction

endpackage

// File: rtl/dht_sensor_ctrl_if.sv
// Host-side bus of the DHT controller: start/mode request plus decoded frame and status.
// Latency: n/a (wires only).
// Backpressure: none; the controller ignores start while busy.
interface dht_sensor_ctrl_if;
    import dht_sensor_ctrl_pkg::*;

    logic               start;
    logic               mode;
    logic [FRAME_W-1:0] data;
    logic [15:0]        humidity;
    logic [15:0]        temperature;
    logic               valid;
    logic               done;
    logic               err_timeout;
    logic               err_checksum;
    logic               busy;
    logic [3:0]         state;

    modport master (
        output start, mode,
        input  data, humidity, temperature, valid, done,
        input  err_timeout, err_checksum, busy, state
    );

    modport slave (
        input  start, mode,
        output data, humidity, temperature, valid, done,
        output err_timeout, err_checksum, busy, state
    );

endinterface

// File: rtl/dht_sensor_ctrl_tick_gen_us.sv
// Free-running 1 us tick: one-cycle pulse every CLK_HZ/1e6 clocks.
// Latency: first tick CLK_HZ/1e6 clocks after reset release.
// Backpressure: none; runs continuously.
module dht_sensor_ctrl_tick_gen_us #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = (CLK_HZ / 1_000_000 > 1) ? CLK_HZ / 1_000_000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divide the system clock down to a 1 us strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dht_sensor_ctrl.sv
// DHT11/DHT22 single-wire host: start pulse, response decode, checksum; auto-poll when DHT_AUTO_POLL_EN is defined.
// Latency: line edges seen 2-3 clk after the pin; done pulses 1 clk after the CHECK/ABORT decision.
// Backpressure: start edges while busy are ignored; a poll falling due while busy waits for IDLE.
module dht_sensor_ctrl
    import dht_sensor_ctrl_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int START_LOW_US11 = 18000,
    parameter int START_LOW_US22 = 1000,
    parameter int BIT_THRESH_US  = 40,
    parameter int TIMEOUT_US     = 200
`ifdef DHT_AUTO_POLL_EN
    ,
    parameter int POLL_MS        = 2000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire              dht_io,
    dht_sensor_ctrl_if.slave bus
);
    localparam logic [15:0] START11_LIM = 16'(START_LOW_US11);
    localparam logic [15:0] START22_LIM = 16'(START_LOW_US22);
    localparam logic [15:0] BIT_LIM     = 16'(BIT_THRESH_US);
    localparam logic [15:0] TO_LIM      = 16'(TIMEOUT_US);
    localparam logic [15:0] STOP_LIM    = 16'd60;

    logic               tick;
    logic               drive_low;
    logic [2:0]         line_sync;
    logic               line_rise;
    logic               line_fall;
    logic               start_q;
    logic               start_rise;
    logic               go;
    dht_state_e         st;
    dht_mode_e          mode_q;
    logic [15:0]        us_cnt;
    logic [15:0]        start_lim;
    logic [5:0]         bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] data_q;
    logic               valid_q;
    logic               done_q;
    logic               err_to_q;
    logic               err_ck_q;

    dht_sensor_ctrl_tick_gen_us #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Open drain: only ever pull low or let the pull-up win
    assign dht_io = drive_low ? 1'b0 : 1'bz;

    // Synchronise the pin and remember the previous sample for edge detection; idle line is high
    always_ff @(posedge clk) begin
        if (rst) line_sync <= 3'b111;
        else     line_sync <= {line_sync[1:0], dht_io};
    end

    assign line_rise = line_sync[1] & ~line_sync[2];
    assign line_fall = ~line_sync[1] & line_sync[2];

    // Previous start level so that a held start triggers only once
    always_ff @(posedge clk) begin
        if (rst) start_q <= 1'b0;
        else     start_q <= bus.start;
    end

    assign start_rise = bus.start & ~start_q;
    assign start_lim  = (mode_q == DHT22) ? START22_LIM : START11_LIM;

`ifdef DHT_AUTO_POLL_EN
    logic [9:0]  poll_us;
    logic [15:0] poll_ms;
    logic        poll_pend;

    // Millisecond poll timer; the request stays pending until the FSM is back in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            poll_us   <= '0;
            poll_ms   <= '0;
            poll_pend <= 1'b0;
        end else begin
            if (st == ST_IDLE) poll_pend <= 1'b0;
            if (tick) begin
                if (poll_us == 10'd999) begin
                    poll_us <= '0;
                    if (poll_ms == 16'(POLL_MS - 1)) begin
                        poll_ms   <= '0;
                        poll_pend <= 1'b1;
                    end else begin
                        poll_ms <= poll_ms + 16'd1;
                    end
                end else begin
                    poll_us <= poll_us + 10'd1;
                end
            end
        end
    end

    assign go = start_rise | poll_pend;
`else
    assign go = start_rise;
`endif

    // Transaction FSM; us_cnt restarts on every transition so each phase is timed from its entry
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            mode_q    <= DHT11;
            us_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            drive_low <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_to_q  <= 1'b0;
            err_ck_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tick) us_cnt <= us_cnt + 16'd1;
            case (st)
                ST_IDLE: if (go) begin
                    mode_q    <= dht_mode_e'(bus.mode);
                    valid_q   <= 1'b0;
                    err_to_q  <= 1'b0;
                    err_ck_q  <= 1'b0;
                    bit_cnt   <= '0;
                    drive_low <= 1'b1;
                    us_cnt    <= '0;
                    st        <= ST_START;
                end
                ST_START: if (us_cnt >= start_lim) begin
                    drive_low <= 1'b0;
                    us_cnt    <= '0;
                    st        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (line_fall) begin
                        us_cnt <= '0;
                        st     <= ST_SYNC_L;
                    end else if (us_cnt >= TO_LIM) begin
                        st <= ST_ABORT;
                    end
                end
                ST_SYNC_L: begin
                    if (line_rise) begin
                        us_cnt <= '0;
                        st     <= ST_SYNC_H;
                    end else if (us_cnt >= TO_LIM) begin
                        st <= ST_ABORT;
                    end
                end
                ST_SYNC_H: begin
                    if (line_fall) begin
                        us_cnt <= '0;
                        st     <= ST_DATA_L;
                    end else if (us_cnt >= TO_LIM) begin
                        st <= ST_ABORT;
                    end
                end
                ST_DATA_L: begin
                    if (line_rise) begin
                        us_cnt <= '0;
                        st     <= ST_DATA_H;
                    end else if (us_cnt >= TO_LIM) begin
                        st <= ST_ABORT;
                    end
                end
                ST_DATA_H: begin
                    // The bit value is the length of the high pulse
                    if (line_fall) begin
                        shreg   <= {shreg[FRAME_W-2:0], (us_cnt > BIT_LIM)};
                        bit_cnt <= bit_cnt + 6'd1;
                        us_cnt  <= '0;
                        st      <= (bit_cnt == 6'(FRAME_W - 1)) ? ST_STOP : ST_DATA_L;
                    end else if (us_cnt >= TO_LIM) begin
                        st <= ST_ABORT;
                    end
                end
                ST_STOP: if (line_rise || us_cnt >= STOP_LIM) begin
                    us_cnt <= '0;
                    st     <= ST_CHECK;
                end
                ST_CHECK: begin
                    // Only a complete frame ever reaches data, good checksum or not
                    data_q <= shreg;
                    if (frame_checksum(shreg) == shreg[7:0]) valid_q  <= 1'b1;
                    else                                    err_ck_q <= 1'b1;
                    done_q <= 1'b1;
                    us_cnt <= '0;
                    st     <= ST_IDLE;
                end
                ST_ABORT: begin
                    err_to_q  <= 1'b1;
                    valid_q   <= 1'b0;
                    drive_low <= 1'b0;
                    done_q    <= 1'b1;
                    us_cnt    <= '0;
                    st        <= ST_IDLE;
                end
                default: begin
                    drive_low <= 1'b0;
                    st        <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data         = data_q;
    assign bus.humidity     = data_q[39:24];
    assign bus.temperature  = data_q[23:8];
    assign bus.valid        = valid_q;
    assign bus.done         = done_q;
    assign bus.err_timeout  = err_to_q;
    assign bus.err_checksum = err_ck_q;
    assign bus.busy         = (st != ST_IDLE);
    assign bus.state        = st;

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// Bench for dht_sensor_ctrl: behavioural open-drain sensor plus a queue of expected transaction results.
// Latency: timing parameters scaled down (2 clk per us, short start lows) to keep the run short.
// Backpressure: n/a.
module tb_dht_sensor_ctrl;
    import dht_sensor_ctrl_pkg::*;

    localparam int CPU = 2;     // clocks per microsecond at CLK_HZ = 2 MHz
    localparam int T11 = 180;
    localparam int T22 = 10;
    localparam int TO  = 200;

    typedef struct packed {
        logic [39:0] data;
        logic        valid;
        logic        err_to;
        logic        err_ck;
    } res_t;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic sensor_low = 1'b0;
    wire  dht_io;

    assign dht_io = sensor_low ? 1'b0 : 1'bz;
    pullup (dht_io);

    dht_sensor_ctrl_if bus();

    dht_sensor_ctrl #(
        .CLK_HZ         (2_000_000),
        .START_LOW_US11 (T11),
        .START_LOW_US22 (T22),
        .BIT_THRESH_US  (40),
        .TIMEOUT_US     (TO)
`ifdef DHT_AUTO_POLL_EN
        ,
        .POLL_MS        (1)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .dht_io (dht_io),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_checks   = 0;
    int          n_fail     = 0;
    res_t        exp_q[$];
    logic [39:0] model_data = '0;

    function automatic res_t frame_result(input logic [39:0] f);
        logic [7:0] s;
        res_t r;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        r.data   = f;
        r.valid  = (s == f[7:0]);
        r.err_to = 1'b0;
        r.err_ck = (s != f[7:0]);
        return r;
    endfunction

    function automatic res_t timeout_result(input logic [39:0] keep);
        res_t r;
        r.data   = keep;
        r.valid  = 1'b0;
        r.err_to = 1'b1;
        r.err_ck = 1'b0;
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_us(input int us);
        cyc(us * CPU);
    endtask

    task automatic wait_line(input logic v, input int limit, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        while (waited < limit && !ok) begin
            if (dht_io === v) ok = 1'b1;
            else begin
                cyc(1);
                waited++;
            end
        end
    endtask

    task automatic wait_done(input int limit, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        while (waited < limit && !ok) begin
            if (bus.done === 1'b1) ok = 1'b1;
            else begin
                cyc(1);
                waited++;
            end
        end
    endtask

    // Raise start, watch the host pull the line low, then time how long it stays low
    task automatic start_txn(input logic m, output int low_cyc, output bit ok);
        int  w;
        bit  ok_a, ok_b;
        bus.mode  = m;
        bus.start = 1'b1;
        wait_line(1'b0, 10, w, ok_a);
        bus.start = 1'b0;
        wait_line(1'b1, (T11 + 5) * CPU, low_cyc, ok_b);
        ok = ok_a && ok_b;
    endtask

    // Sensor reply: 80/80 us sync, then nbits of 20 us low + 28 us (0) or 70 us (1) high
    task automatic send_resp(input logic [39:0] f, input int nbits);
        hold_us(20);
        sensor_low = 1'b1; hold_us(80);
        sensor_low = 1'b0; hold_us(80);
        for (int i = 0; i < nbits; i++) begin
            sensor_low = 1'b1; hold_us(20);
            sensor_low = 1'b0; hold_us(f[39 - i] ? 70 : 28);
        end
        if (nbits == 40) begin
            sensor_low = 1'b1; hold_us(20);
            sensor_low = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(5);
        rst = 1'b0;
        cyc(1);
        n_checks++;
        if ({bus.data, bus.valid, bus.done, bus.err_timeout, bus.err_checksum, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h valid=%b done=%b err_to=%b err_ck=%b busy=%b, want all 0",
                     bus.data, bus.valid, bus.done, bus.err_timeout, bus.err_checksum, bus.busy);
        end
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", bus.state);
        end
        n_checks++;
        if (dht_io !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_line: got %b want 1 (released)", dht_io);
        end
    endtask

    task automatic test_no_response();
        int   low, w;
        bit   ok;
        res_t e, o;
        exp_q.push_back(timeout_result(model_data));
        start_txn(1'b0, low, ok);
        n_checks++;
        if (!ok || low < (T11 - 1) * CPU || low > (T11 + 1) * CPU) begin
            n_fail++;
            $display("FAIL dht11_start_low: got %0d clk ok=%b want %0d..%0d", low, ok, (T11 - 1) * CPU, (T11 + 1) * CPU);
        end
        wait_done(4000, w, ok);
        n_checks++;
        if (!ok || w < TO * CPU - 2 || w > TO * CPU + 6) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d clk ok=%b want about %0d", w, ok, TO * CPU);
        end
        e = exp_q.pop_front();
        o = {bus.data, bus.valid, bus.err_timeout, bus.err_checksum};
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL no_response_result: got %h want %h", o, e);
        end
        cyc(1);
        n_checks++;
        if (bus.busy !== 1'b0 || dht_io !== 1'b1) begin
            n_fail++;
            $display("FAIL no_response_idle: busy=%b line=%b want busy=0 line=1", bus.busy, dht_io);
        end
    endtask

    task automatic test_frame(input string name, input logic [39:0] f);
        int   low, w;
        bit   ok;
        res_t e, o;
        exp_q.push_back(frame_result(f));
        start_txn(1'b0, low, ok);
        send_resp(f, 40);
        wait_done(400, w, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_done: no done within %0d clk", name, w);
        end
        e = exp_q.pop_front();
        o = {bus.data, bus.valid, bus.err_timeout, bus.err_checksum};
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL %s_result: got %h want %h", name, o, e);
        end
        n_checks++;
        if (bus.humidity !== f[39:24] || bus.temperature !== f[23:8]) begin
            n_fail++;
            $display("FAIL %s_fields: hum=%h temp=%h want %h %h", name, bus.humidity, bus.temperature, f[39:24], f[23:8]);
        end
        model_data = f;
        cyc(1);
    endtask

    task automatic test_partial_abort();
        int   low, w;
        bit   ok;
        res_t e, o;
        exp_q.push_back(timeout_result(model_data));
        start_txn(1'b0, low, ok);
        send_resp(40'hAA_55_AA_55_FF, 17);
        wait_done(1000, w, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL partial_done: no done within %0d clk", w);
        end
        e = exp_q.pop_front();
        o = {bus.data, bus.valid, bus.err_timeout, bus.err_checksum};
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL partial_result: got %h want %h", o, e);
        end
        cyc(1);
    endtask

    task automatic test_dht22_busy_start();
        int   low, w;
        bit   ok, restarted;
        res_t e, o;
        exp_q.push_back(timeout_result(model_data));
        start_txn(1'b1, low, ok);
        n_checks++;
        if (!ok || low < (T22 - 1) * CPU || low > (T22 + 1) * CPU) begin
            n_fail++;
            $display("FAIL dht22_start_low: got %0d clk ok=%b want %0d..%0d", low, ok, (T22 - 1) * CPU, (T22 + 1) * CPU);
        end
        cyc(10);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_wait: got %b want 1", bus.busy);
        end
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        cyc(4);
        bus.start = 1'b0;
        wait_done(1000, w, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dht22_done: no done within %0d clk", w);
        end
        e = exp_q.pop_front();
        o = {bus.data, bus.valid, bus.err_timeout, bus.err_checksum};
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL dht22_result: got %h want %h", o, e);
        end
        restarted = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (bus.busy !== 1'b0 || dht_io !== 1'b1) restarted = 1'b1;
        end
        n_checks++;
        if (restarted) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got restart=1 want 0");
        end
    endtask

    task automatic test_reset_mid();
        int low, w;
        bit ok;
        // reset while the host is driving the start low
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        wait_line(1'b0, 10, w, ok);
        bus.start = 1'b0;
        cyc(20);
        rst = 1'b1;
        cyc(1);
        n_checks++;
        if (dht_io !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_line: got %b want 1", dht_io);
        end
        rst = 1'b0;
        cyc(2);
        // reset in the middle of a data bit
        start_txn(1'b0, low, ok);
        send_resp(40'hF0_0F_33_CC_FE, 5);
        cyc(4);
        n_checks++;
        if (bus.state !== ST_DATA_H) begin
            n_fail++;
            $display("FAIL mid_frame_state: got %0d want %0d", bus.state, ST_DATA_H);
        end
        rst = 1'b1;
        cyc(1);
        n_checks++;
        if ({bus.data, bus.humidity, bus.temperature, bus.valid, bus.done, bus.err_timeout,
             bus.err_checksum, bus.busy, bus.state} !== '0 || dht_io !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: data=%h valid=%b err_to=%b busy=%b state=%0d line=%b want 0s, line 1",
                     bus.data, bus.valid, bus.err_timeout, bus.busy, bus.state, dht_io);
        end
        rst = 1'b0;
        cyc(2);
    endtask

`ifdef DHT_AUTO_POLL_EN
    task automatic test_auto_poll();
        int   w;
        bit   ok;
        res_t e, o;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(timeout_result(40'h0));
            wait_done(4000, w, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL poll_done_%0d: no done within %0d clk", k, w);
            end
            if (k > 0) begin
                n_checks++;
                if (w + 1 < 1000 * CPU - 4 || w + 1 > 1000 * CPU + 4) begin
                    n_fail++;
                    $display("FAIL poll_period_%0d: got %0d clk want %0d", k, w + 1, 1000 * CPU);
                end
            end
            e = exp_q.pop_front();
            o = {bus.data, bus.valid, bus.err_timeout, bus.err_checksum};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL poll_result_%0d: got %h want %h", k, o, e);
            end
            cyc(1);
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        test_reset();
`ifdef DHT_AUTO_POLL_EN
        test_auto_poll();
`else
        test_no_response();
        test_frame("bad_checksum", 40'h12_34_56_78_9A);
        test_frame("good_frame", 40'h35_00_18_00_4D);
        test_partial_abort();
        test_dht22_busy_start();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
